// File: rtl/vram_pkg.sv
// Shared VRAM definitions: request owner tag and default geometry of the
// arbitrated video memory.
package vram_pkg;

    localparam int VRAM_AW        = 16;
    localparam int VRAM_DW        = 12;
    localparam int VRAM_BURST_MAX = 4;

    typedef enum logic {
        OWN_DISP = 1'b0,
        OWN_CPU  = 1'b1
    } owner_e;

endpackage : vram_pkg

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display has fixed priority, bounded by a burst limit
// so a waiting CPU is served at least once every BURST_MAX+1 cycles.
// Define VRAM_ARB_STATS_EN to add grant counters and a CPU worst-wait statistic.
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW        = VRAM_AW,
    parameter int DW        = VRAM_DW,
    parameter int BURST_MAX = VRAM_BURST_MAX
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          disp_valid,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_ready,
    output logic          disp_rvalid,
    output logic [DW-1:0] disp_rdata,

    input  logic          cpu_valid,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,

    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [31:0]   stat_disp,
    output logic [31:0]   stat_cpu,
    output logic [15:0]   stat_wait_max
`endif
);

    localparam int            BW        = $clog2(BURST_MAX + 1);
    localparam logic [BW-1:0] BURST_LIM = BW'(BURST_MAX);

    logic [BW-1:0] burst_q, burst_d;
    logic          tag_valid_q, tag_valid_d;
    owner_e        tag_owner_q, tag_owner_d;

    logic force_cpu;
    logic disp_grant;
    logic cpu_grant;

    // Arbitration; both readies are held low during reset so nothing is granted.
    always_comb begin
        force_cpu  = cpu_valid && (burst_q == BURST_LIM);
        disp_ready = !rst && disp_valid && !force_cpu;
        cpu_ready  = !rst && cpu_valid && !(disp_valid && !force_cpu);
        disp_grant = disp_valid && disp_ready;
        cpu_grant  = cpu_valid && cpu_ready;
    end

    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = disp_addr;
        mem_wdata = '0;
        if (disp_grant) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end else if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end
    end

    always_comb begin
        burst_d = burst_q;
        if (rst || cpu_grant || !cpu_valid) begin
            burst_d = '0;
        end else if (disp_grant && (burst_q != BURST_LIM)) begin
            burst_d = burst_q + BW'(1);
        end
    end

    // Read tag: one entry is enough because memory read latency is one cycle.
    always_comb begin
        tag_valid_d = 1'b0;
        tag_owner_d = tag_owner_q;
        if (!rst) begin
            if (disp_grant) begin
                tag_valid_d = 1'b1;
                tag_owner_d = OWN_DISP;
            end else if (cpu_grant && !cpu_we) begin
                tag_valid_d = 1'b1;
                tag_owner_d = OWN_CPU;
            end
        end else begin
            tag_owner_d = OWN_DISP;
        end
    end

    // NOTE: sequential state uses non-blocking assignments; reset is folded into the _d logic.
    always_ff @(posedge clk) begin
        burst_q     <= burst_d;
        tag_valid_q <= tag_valid_d;
        tag_owner_q <= tag_owner_d;
    end

    assign disp_rvalid = tag_valid_q && (tag_owner_q == OWN_DISP);
    assign cpu_rvalid  = tag_valid_q && (tag_owner_q == OWN_CPU);
    assign disp_rdata  = mem_rdata;
    assign cpu_rdata   = mem_rdata;

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] stat_disp_q, stat_disp_d;
    logic [31:0] stat_cpu_q, stat_cpu_d;
    logic [15:0] wait_cnt_q, wait_cnt_d;
    logic [15:0] wait_max_q, wait_max_d;

    // wait_cnt_q holds the cycles the current CPU request has been refused so far.
    always_comb begin
        stat_disp_d = stat_disp_q;
        stat_cpu_d  = stat_cpu_q;
        wait_cnt_d  = wait_cnt_q;
        wait_max_d  = wait_max_q;
        if (rst) begin
            stat_disp_d = '0;
            stat_cpu_d  = '0;
            wait_cnt_d  = '0;
            wait_max_d  = '0;
        end else begin
            if (disp_grant) begin
                stat_disp_d = stat_disp_q + 32'd1;
            end
            if (cpu_grant) begin
                stat_cpu_d = stat_cpu_q + 32'd1;
                wait_cnt_d = '0;
                if (wait_cnt_q > wait_max_q) begin
                    wait_max_d = wait_cnt_q;
                end
            end else if (cpu_valid) begin
                if (wait_cnt_q != 16'hFFFF) begin
                    wait_cnt_d = wait_cnt_q + 16'd1;
                end
            end else begin
                wait_cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        stat_disp_q <= stat_disp_d;
        stat_cpu_q  <= stat_cpu_d;
        wait_cnt_q  <= wait_cnt_d;
        wait_max_q  <= wait_max_d;
    end

    assign stat_disp     = stat_disp_q;
    assign stat_cpu      = stat_cpu_q;
    assign stat_wait_max = wait_max_q;
`endif

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural 1-cycle-latency VRAM.
// Stat checks are included when VRAM_ARB_STATS_EN is defined.
module tb_vram_arbiter;

    localparam int AW = 16;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst;
    logic          disp_valid;
    logic [AW-1:0] disp_addr;
    logic          disp_ready;
    logic          disp_rvalid;
    logic [DW-1:0] disp_rdata;
    logic          cpu_valid;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
`ifdef VRAM_ARB_STATS_EN
    logic [31:0]   stat_disp;
    logic [31:0]   stat_cpu;
    logic [15:0]   stat_wait_max;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    vram_arbiter #(.AW(AW), .DW(DW), .BURST_MAX(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .disp_valid  (disp_valid),
        .disp_addr   (disp_addr),
        .disp_ready  (disp_ready),
        .disp_rvalid (disp_rvalid),
        .disp_rdata  (disp_rdata),
        .cpu_valid   (cpu_valid),
        .cpu_we      (cpu_we),
        .cpu_addr    (cpu_addr),
        .cpu_wdata   (cpu_wdata),
        .cpu_ready   (cpu_ready),
        .cpu_rvalid  (cpu_rvalid),
        .cpu_rdata   (cpu_rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_disp     (stat_disp),
        .stat_cpu      (stat_cpu),
        .stat_wait_max (stat_wait_max)
`endif
    );

    // Behavioural VRAM; a few known words are loaded while rst is high.
    logic [DW-1:0] vram [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (rst) begin
            vram[16'h0010] <= 12'h111;
            vram[16'h0011] <= 12'h222;
            vram[16'h0012] <= 12'h333;
            vram[16'h0030] <= 12'h5A5;
            mem_rdata      <= '0;
        end else if (mem_en && mem_we) begin
            vram[mem_addr] <= mem_wdata;
        end else if (mem_en) begin
            mem_rdata <= vram[mem_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    logic exp_cpu;
    logic prev_d;
    logic prev_c;

    initial begin
        rst        = 1'b1;
        disp_valid = 1'b1;
        disp_addr  = 16'h0010;
        cpu_valid  = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h0030;
        cpu_wdata  = '0;

        // Reset: readies and mem_en gated low even with both requesters active.
        settle();
        check("rst_disp_ready", 32'(disp_ready), 32'd0);
        check("rst_cpu_ready",  32'(cpu_ready),  32'd0);
        check("rst_mem_en",     32'(mem_en),     32'd0);
        next_cycle();
        disp_valid = 1'b0;
        cpu_valid  = 1'b0;
        next_cycle();
        rst = 1'b0;
        settle();
        check("rst_disp_rvalid", 32'(disp_rvalid), 32'd0);
        check("rst_cpu_rvalid",  32'(cpu_rvalid),  32'd0);
        next_cycle();

        // Display-only reads of 0x10..0x12.
        disp_valid = 1'b1;
        disp_addr  = 16'h0010;
        settle();
        check("d1_ready",    32'(disp_ready),  32'd1);
        check("d1_mem_en",   32'(mem_en),      32'd1);
        check("d1_mem_addr", 32'(mem_addr),    32'h10);
        check("d1_mem_we",   32'(mem_we),      32'd0);
        check("d1_cpu_rdy",  32'(cpu_ready),   32'd0);
        check("d1_rvalid",   32'(disp_rvalid), 32'd0);
        next_cycle();
        disp_addr = 16'h0011;
        settle();
        check("d2_ready",  32'(disp_ready),  32'd1);
        check("d2_rvalid", 32'(disp_rvalid), 32'd1);
        check("d2_rdata",  32'(disp_rdata),  32'h111);
        next_cycle();
        disp_addr = 16'h0012;
        settle();
        check("d3_ready",  32'(disp_ready),  32'd1);
        check("d3_rvalid", 32'(disp_rvalid), 32'd1);
        check("d3_rdata",  32'(disp_rdata),  32'h222);
        next_cycle();
        disp_valid = 1'b0;
        settle();
        check("d4_ready",      32'(disp_ready),  32'd0);
        check("d4_mem_en",     32'(mem_en),      32'd0);
        check("d4_rvalid",     32'(disp_rvalid), 32'd1);
        check("d4_rdata",      32'(disp_rdata),  32'h333);
        check("d4_cpu_rvalid", 32'(cpu_rvalid),  32'd0);
        next_cycle();
        settle();
        check("d5_rvalid", 32'(disp_rvalid), 32'd0);

        // CPU write 0xABC to 0x20, then read it back.
        cpu_valid = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0020;
        cpu_wdata = 12'hABC;
        next_cycle();
        settle();
        check("cw_ready",     32'(cpu_ready), 32'd1);
        check("cw_mem_we",    32'(mem_we),    32'd1);
        check("cw_mem_addr",  32'(mem_addr),  32'h20);
        check("cw_mem_wdata", 32'(mem_wdata), 32'hABC);
        next_cycle();
        cpu_we    = 1'b0;
        cpu_wdata = '0;
        settle();
        check("cr_ready",        32'(cpu_ready),  32'd1);
        check("cr_mem_we",       32'(mem_we),     32'd0);
        check("cw_no_rvalid",    32'(cpu_rvalid), 32'd0);
        next_cycle();
        cpu_valid = 1'b0;
        settle();
        check("cr_rvalid",      32'(cpu_rvalid),  32'd1);
        check("cr_rdata",       32'(cpu_rdata),   32'hABC);
        check("cr_disp_rvalid", 32'(disp_rvalid), 32'd0);
        next_cycle();

        // Display read granted, then rst on the following cycle with requests held.
        disp_valid = 1'b1;
        disp_addr  = 16'h0010;
        settle();
        check("rg_ready", 32'(disp_ready), 32'd1);
        next_cycle();
        rst       = 1'b1;
        disp_addr = 16'h0011;
        cpu_valid = 1'b1;
        cpu_addr  = 16'h0030;
        settle();
        check("rg_disp_ready", 32'(disp_ready), 32'd0);
        check("rg_cpu_ready",  32'(cpu_ready),  32'd0);
        check("rg_mem_en",     32'(mem_en),     32'd0);
        next_cycle();
        rst        = 1'b0;
        disp_valid = 1'b0;
        cpu_valid  = 1'b0;
        settle();
        check("rg_disp_rvalid", 32'(disp_rvalid), 32'd0);
        check("rg_cpu_rvalid",  32'(cpu_rvalid),  32'd0);
        check("rg_mem_we",      32'(mem_we),      32'd0);
        next_cycle();

        // Both requesters continuous: 4 display grants then 1 CPU grant.
        disp_valid = 1'b1;
        disp_addr  = 16'h0010;
        cpu_valid  = 1'b1;
        cpu_we     = 1'b0;
        cpu_addr   = 16'h0030;
        for (int i = 0; i < 20; i++) begin
            exp_cpu = ((i % 5) == 4);
            settle();
            check($sformatf("bu%0d_disp_ready", i), 32'(disp_ready), 32'(!exp_cpu));
            check($sformatf("bu%0d_cpu_ready", i),  32'(cpu_ready),  32'(exp_cpu));
            check($sformatf("bu%0d_exclusive", i),  32'(disp_ready && cpu_ready), 32'd0);
            next_cycle();
        end
        disp_valid = 1'b0;
        cpu_valid  = 1'b0;
        settle();
        check("bu_cpu_rvalid", 32'(cpu_rvalid), 32'd1);
        check("bu_cpu_rdata",  32'(cpu_rdata),  32'h5A5);
`ifdef VRAM_ARB_STATS_EN
        check("stat_disp",     stat_disp,            32'd16);
        check("stat_cpu",      stat_cpu,             32'd4);
        check("stat_wait_max", 32'(stat_wait_max),   32'd4);
`endif
        next_cycle();

        // Scanner requests 1 of 4 cycles; CPU reads fill the remaining cycles.
        prev_d    = 1'b0;
        prev_c    = 1'b0;
        disp_addr = 16'h0011;
        cpu_addr  = 16'h0030;
        cpu_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            disp_valid = ((i % 4) == 0);
            settle();
            check($sformatf("sc%0d_no_stall", i),    32'(disp_ready),  32'((i % 4) == 0));
            check($sformatf("sc%0d_cpu_ready", i),   32'(cpu_ready),   32'((i % 4) != 0));
            check($sformatf("sc%0d_disp_rvalid", i), 32'(disp_rvalid), 32'(prev_d));
            check($sformatf("sc%0d_cpu_rvalid", i),  32'(cpu_rvalid),  32'(prev_c));
            if (prev_d) check($sformatf("sc%0d_disp_rdata", i), 32'(disp_rdata), 32'h222);
            if (prev_c) check($sformatf("sc%0d_cpu_rdata", i),  32'(cpu_rdata),  32'h5A5);
            prev_d = ((i % 4) == 0);
            prev_c = ((i % 4) != 0);
            next_cycle();
        end
        disp_valid = 1'b0;
        cpu_valid  = 1'b0;
        next_cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vram_arbiter
